// File: rtl/pb_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : pb_debounce
//  Purpose  : Three-channel push-button conditioner. Each raw, bouncing button
//             pin is passed through a two-flop synchroniser, optionally
//             inverted, and then qualified by a stable-count debouncer. The
//             result is a clean, active-high level per button.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEBOUNCE_CYCLES  consecutive cycles a new level must persist (2..2^24)
//    CNT_W            qualification counter width
//    INV_MASK         bit i set -> button i+1 is active-low at the pin
//  Ports
//    clk                       system clock, rising edge
//    rst                       asynchronous reset, active low
//    pb1_raw/pb2_raw/pb3_raw   raw button pins, asynchronous to clk
//    pb1/pb2/pb3               debounced active-high levels (registered)
//    pb_busy                   some channel is qualifying a change (registered)
// ============================================================================
module pb_debounce #(
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter int         CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter logic [2:0] INV_MASK        = 3'b000
) (
    input  logic clk,
    input  logic rst,
    input  logic pb1_raw,
    input  logic pb2_raw,
    input  logic pb3_raw,
    output logic pb1,
    output logic pb2,
    output logic pb3,
    output logic pb_busy
);

    // Counter value seen on the final qualifying cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0] raw_w;
    logic [2:0] counting_w;
    logic [2:0] out_w;
    logic       busy_d;
    logic       busy_q;

    assign raw_w = {pb3_raw, pb2_raw, pb1_raw};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_ch
            logic             sync1_q;
            logic             sync2_q;
            logic             out_q;
            logic             out_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             sample_w;

            // Synchroniser flops reset to the inactive pin level, so the
            // logical sample is 0 straight out of reset.
            assign sample_w      = sync2_q ^ INV_MASK[i];
            // The channel state is implied: COUNTING whenever the sample
            // disagrees with the accepted level, STABLE otherwise.
            assign counting_w[i] = (sample_w != out_q);
            assign out_w[i]      = out_q;

            // Any cycle of agreement (glitch) drops the count back to zero;
            // acceptance takes the new level and clears the count together.
            always_comb begin
                cnt_d = '0;
                out_d = out_q;
                if (counting_w[i]) begin
                    if (cnt_q == CNT_LAST) begin
                        out_d = sample_w;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_q <= INV_MASK[i];
                    sync2_q <= INV_MASK[i];
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                end else begin
                    sync1_q <= raw_w[i];
                    sync2_q <= sync1_q;
                    cnt_q   <= cnt_d;
                    out_q   <= out_d;
                end
            end
        end
    endgenerate

    assign busy_d = |counting_w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign pb1     = out_w[0];
    assign pb2     = out_w[1];
    assign pb3     = out_w[2];
    assign pb_busy = busy_q;

endmodule
`default_nettype wire
